// File: rtl/gate_test_pkg.sv
// Shared types and truth-table constants for the on-chip two-input gate testers.
package gate_test_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef logic [1:0] vec_idx_t;

    localparam logic [3:0] TT_INHIBIT = 4'b0100;
    localparam logic [3:0] TT_AND     = 4'b1000;
    localparam logic [3:0] TT_OR      = 4'b1110;

    localparam vec_idx_t LAST_VEC = 2'd3;

    // A counter that must reach HOLD_CYCLES-1 needs clog2(HOLD_CYCLES) bits, never fewer than one.
    function automatic int hold_width(input int hold);
        return (hold > 1) ? $clog2(hold) : 1;
    endfunction

endpackage

// File: rtl/gate_vector_tester_hold_timer.sv
// Loadable down-counter; tc_o is high while the count sits at zero.
module hold_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/gate_vector_tester.sv
// Drives the four {a,b} vectors to a two-input gate, holds each HOLD_CYCLES cycles,
// and checks the gate output on each vector's last hold cycle against TRUTH.
module gate_vector_tester
    import gate_test_pkg::*;
#(
    parameter int         HOLD_CYCLES = 50,
    parameter logic [3:0] TRUTH       = TT_INHIBIT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       stim_a,
    output logic       stim_b,
    input  logic       dut_y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_mask,
    output logic [2:0] err_count,
    output logic [1:0] dbg_state
);

    localparam int            HW        = hold_width(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    vec_idx_t   vec_q, vec_d;
    logic [1:0] stim_q, stim_d;
    logic [3:0] err_mask_q, err_mask_d;
    logic [2:0] err_count_q, err_count_d;
    logic       pass_q, pass_d;

    logic          timer_load;
    logic          timer_en;
    logic          timer_tc;
    logic [HW-1:0] timer_count;
    logic          mismatch;

    hold_timer #(
        .WIDTH(HW)
    ) u_hold_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (timer_load),
        .en_i      (timer_en),
        .load_val_i(HOLD_LOAD),
        .count_o   (timer_count),
        .tc_o      (timer_tc)
    );

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        stim_d      = stim_q;
        err_mask_d  = err_mask_q;
        err_count_d = err_count_q;
        pass_d      = pass_q;
        timer_load  = 1'b0;
        timer_en    = 1'b0;
        mismatch    = 1'b0;

        case (state_q)
            IDLE: begin
                stim_d = 2'b00;
                if (start) begin
                    state_d     = RUN;
                    vec_d       = '0;
                    err_mask_d  = '0;
                    err_count_d = '0;
                    pass_d      = 1'b0;
                    timer_load  = 1'b1;
                end
            end
            RUN: begin
                timer_en = 1'b1;
                // Terminal count marks the last hold cycle of the current vector.
                if (timer_tc) begin
                    mismatch   = (dut_y != TRUTH[vec_q]);
                    timer_load = 1'b1;
                    if (mismatch) begin
                        err_mask_d[vec_q] = 1'b1;
                        err_count_d       = err_count_q + 3'd1;
                    end
                    if (vec_q == LAST_VEC) begin
                        state_d = DONE;
                        stim_d  = 2'b00;
                        pass_d  = (err_count_d == 3'd0);
                    end else begin
                        vec_d  = vec_q + 2'd1;
                        stim_d = vec_q + 2'd1;
                    end
                end
            end
            DONE: begin
                stim_d  = 2'b00;
                state_d = IDLE;
            end
            default: begin
                stim_d  = 2'b00;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vec_q       <= '0;
            stim_q      <= 2'b00;
            err_mask_q  <= '0;
            err_count_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            stim_q      <= stim_d;
            err_mask_q  <= err_mask_d;
            err_count_q <= err_count_d;
            pass_q      <= pass_d;
        end
    end

    assign stim_a    = stim_q[1];
    assign stim_b    = stim_q[0];
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_mask  = err_mask_q;
    assign err_count = err_count_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_gate_vector_tester.sv
// Bench for gate_vector_tester: table of gate models with expected results, plus
// hand-written sequences for ignored restart, mid-run reset and HOLD_CYCLES = 1.
module tb_gate_vector_tester;
    import gate_test_pkg::*;

    logic clk;
    logic rst_n;

    logic       start50, a50, b50, y50, busy50, done50, pass50;
    logic [3:0] mask50;
    logic [2:0] cnt50;
    logic [1:0] st50;

    logic       start1, a1, b1, y1, busy1, done1, pass1;
    logic [3:0] mask1;
    logic [2:0] cnt1;
    logic [1:0] st1;

    int mode;
    int sel;
    int n_vec;
    int n_err;

    logic [1:0] exp_q[$];

    logic       a_m, b_m, busy_m, done_m, pass_m;
    logic [3:0] mask_m;
    logic [2:0] cnt_m;

    typedef struct {
        int         mode;
        logic       exp_pass;
        logic [3:0] exp_mask;
        logic [2:0] exp_cnt;
    } vec_t;

    vec_t tbl[5];

    gate_vector_tester #(.HOLD_CYCLES(50), .TRUTH(TT_INHIBIT)) dut50 (
        .clk(clk), .rst_n(rst_n), .start(start50), .stim_a(a50), .stim_b(b50),
        .dut_y(y50), .busy(busy50), .done(done50), .pass(pass50),
        .err_mask(mask50), .err_count(cnt50), .dbg_state(st50)
    );

    gate_vector_tester #(.HOLD_CYCLES(1), .TRUTH(TT_INHIBIT)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stim_a(a1), .stim_b(b1),
        .dut_y(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_mask(mask1), .err_count(cnt1), .dbg_state(st1)
    );

    // Gate models: 0 inhibit, 1 tied low, 2 AND, 3 tied high, 4 inverted inhibit.
    function automatic logic gate_fn(input int m, input logic a, input logic b);
        case (m)
            0:       return a & ~b;
            1:       return 1'b0;
            2:       return a & b;
            3:       return 1'b1;
            default: return ~(a & ~b);
        endcase
    endfunction

    always_comb begin
        y50 = gate_fn(mode, a50, b50);
        y1  = gate_fn(mode, a1, b1);
    end

    always_comb begin
        a_m    = (sel == 0) ? a50    : a1;
        b_m    = (sel == 0) ? b50    : b1;
        busy_m = (sel == 0) ? busy50 : busy1;
        done_m = (sel == 0) ? done50 : done1;
        pass_m = (sel == 0) ? pass50 : pass1;
        mask_m = (sel == 0) ? mask50 : mask1;
        cnt_m  = (sel == 0) ? cnt50  : cnt1;
    end

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver and checking tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int which, input logic v);
        if (which == 0) start50 = v;
        else            start1  = v;
    endtask

    // Called at a negedge with the DUT in IDLE; start is sampled at the next posedge (E0).
    task automatic run_test(input int which, input int h, input logic exp_pass,
                            input logic [3:0] exp_mask, input logic [2:0] exp_cnt,
                            input int repulse_at);
        int n;
        sel = which;
        for (int v = 0; v < 4; v++) exp_q.push_back(2'(v));
        set_start(which, 1'b1);
        @(negedge clk);
        set_start(which, 1'b0);
        n = 0;
        check("busy_after_start", busy_m, 1);
        while (!done_m && n < 4 * h + 20) begin
            if ((n % h) == h - 1 && exp_q.size() > 0)
                check("stim_vec", {a_m, b_m}, exp_q.pop_front());
            if (n == repulse_at) set_start(which, 1'b1);
            @(negedge clk);
            set_start(which, 1'b0);
            n++;
        end
        if (!done_m) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_latency", n, 4 * h);
            check("pass", pass_m, exp_pass);
            check("err_mask", mask_m, exp_mask);
            check("err_count", cnt_m, exp_cnt);
            check("busy_at_done", busy_m, 0);
            check("stim_at_done", {a_m, b_m}, 2'b00);
        end
        if (exp_q.size() != 0) check("stim_vec_count", exp_q.size(), 0);
        exp_q.delete();
        @(negedge clk);
        check("done_fall", done_m, 0);
        check("results_hold", {pass_m, mask_m, cnt_m}, {exp_pass, exp_mask, exp_cnt});
        check("no_queued_run", busy_m, 0);
    endtask

    // Stimulus
    initial begin
        n_vec   = 0;
        n_err   = 0;
        mode    = 0;
        sel     = 0;
        start50 = 1'b0;
        start1  = 1'b0;
        rst_n   = 1'b0;

        tbl[0] = '{mode: 0, exp_pass: 1'b1, exp_mask: 4'b0000, exp_cnt: 3'd0};
        tbl[1] = '{mode: 1, exp_pass: 1'b0, exp_mask: 4'b0100, exp_cnt: 3'd1};
        tbl[2] = '{mode: 2, exp_pass: 1'b0, exp_mask: 4'b1100, exp_cnt: 3'd2};
        tbl[3] = '{mode: 3, exp_pass: 1'b0, exp_mask: 4'b1011, exp_cnt: 3'd3};
        tbl[4] = '{mode: 4, exp_pass: 1'b0, exp_mask: 4'b1111, exp_cnt: 3'd4};

        repeat (2) @(negedge clk);
        check("reset_outputs_h50", {a50, b50, busy50, done50, pass50, mask50, cnt50, st50}, 0);
        check("reset_outputs_h1", {a1, b1, busy1, done1, pass1, mask1, cnt1, st1}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            mode = tbl[i].mode;
            run_test(0, 50, tbl[i].exp_pass, tbl[i].exp_mask, tbl[i].exp_cnt, -1);
        end

        // Restart request while vector 01 is held must be ignored.
        mode = 0;
        run_test(0, 50, 1'b1, 4'b0000, 3'd0, 60);

        // Reset during vector 10 after two recorded mismatches.
        mode = 4;
        sel  = 0;
        start50 = 1'b1;
        @(negedge clk);
        start50 = 1'b0;
        repeat (120) @(negedge clk);
        check("midrun_state", {busy50, a50, b50, mask50, cnt50}, {1'b1, 2'b10, 4'b0011, 3'd2});
        rst_n = 1'b0;
        #1;
        check("midrun_reset_outputs", {a50, b50, busy50, done50, pass50, mask50, cnt50, st50}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mode = 0;
        run_test(0, 50, 1'b1, 4'b0000, 3'd0, -1);

        // Single-cycle hold, back-to-back runs, then a failing gate.
        run_test(1, 1, 1'b1, 4'b0000, 3'd0, -1);
        run_test(1, 1, 1'b1, 4'b0000, 3'd0, -1);
        mode = 1;
        run_test(1, 1, 1'b0, 4'b0100, 3'd1, -1);

        // Final report
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
